// File: rtl/baseband_capture_if.sv
// Sample input and CSR readout signals of the baseband snapshot buffer.
interface baseband_capture_if #(
   parameter int unsigned DW = 16
);
   logic [DW-1:0]   in_x;
   logic [DW-1:0]   in_y;
   logic            in_valid;
   logic            rd_stb;
   logic [2*DW-1:0] rd_data;
   logic            rd_valid;

   // Sample source / CPU side
   modport master (
      output in_x, in_y, in_valid, rd_stb,
      input  rd_data, rd_valid
   );

   // Capture buffer side
   modport slave (
      input  in_x, in_y, in_valid, rd_stb,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/baseband_capture.sv
// Snapshot buffer for decimated I/Q pairs: arm, optional rising-edge trigger
// on y, capture into block RAM, then pop one pair per rd_stb.
module baseband_capture #(
   parameter int unsigned DW = 16,
   parameter int unsigned AW = 10
) (
   input  logic              sys_clk,
   input  logic              rst,
   baseband_capture_if.slave bus,
   input  logic              arm,
   input  logic              trig_mode,
   input  logic [DW-1:0]     trig_level,
   input  logic [AW:0]       num_samples,
   output logic              busy,
   output logic              done,
   output logic [AW:0]       wr_count,
   output logic [AW:0]       rd_count,
   output logic              underflow
);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [CW-1:0]       wr_count_q, wr_count_d;
   logic [CW-1:0]       rd_count_q, rd_count_d;
   logic [CW-1:0]       target_q, target_d;
   logic signed [DW-1:0] prev_y_q, prev_y_d;
   logic                underflow_q, underflow_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rd_pend_q;
   logic                rd_valid_q;
   logic [2*DW-1:0]     rd_data_q;
   logic [2*DW-1:0]     ram_q;
   logic [2*DW-1:0]     mem [2**AW];

   logic                trig_hit_c;
   logic [CW-1:0]       wr_next_c;
   logic                wr_en_c;
   logic [AW-1:0]       wr_addr_c;
   logic                rd_go_c;

   assign trig_hit_c = (prev_y_q < $signed(trig_level)) &&
                       ($signed(bus.in_y) >= $signed(trig_level));
   assign wr_next_c  = wr_count_q + CW'(1);

   // State register
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; arm overrides every state
   always_comb begin
      state_d = state_q;
      if (arm) begin
         state_d = S_ARMED;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (!trig_mode) begin
                  state_d = S_CAPTURE;
               end else if (bus.in_valid && trig_hit_c) begin
                  state_d = (target_q == CW'(1)) ? S_DONE : S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               if (bus.in_valid && (wr_next_c == target_q)) state_d = S_DONE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Datapath next values, RAM controls and status flags
   always_comb begin
      wr_count_d  = wr_count_q;
      rd_count_d  = rd_count_q;
      target_d    = target_q;
      prev_y_d    = prev_y_q;
      underflow_d = underflow_q;
      wr_en_c     = 1'b0;
      wr_addr_c   = wr_count_q[AW-1:0];
      rd_go_c     = 1'b0;
      busy_d      = (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_d      = (state_d == S_DONE);
      if (arm) begin
         wr_count_d  = '0;
         rd_count_d  = '0;
         underflow_d = 1'b0;
         prev_y_d    = '0;
         target_d    = ((num_samples == '0) || (num_samples > DEPTH)) ? DEPTH : num_samples;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (trig_mode && bus.in_valid) begin
                  prev_y_d = $signed(bus.in_y);
                  if (trig_hit_c) begin
                     wr_en_c    = 1'b1;
                     wr_addr_c  = '0;
                     wr_count_d = CW'(1);
                  end
               end
            end
            S_CAPTURE: begin
               if (bus.in_valid) begin
                  wr_en_c    = 1'b1;
                  wr_count_d = wr_next_c;
               end
            end
            S_DONE: begin
               if (bus.rd_stb) begin
                  if (rd_count_q != wr_count_q) begin
                     rd_go_c    = 1'b1;
                     rd_count_d = rd_count_q + CW'(1);
                  end else begin
                     underflow_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control and status registers
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         wr_count_q  <= '0;
         rd_count_q  <= '0;
         target_q    <= '0;
         prev_y_q    <= '0;
         underflow_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         wr_count_q  <= wr_count_d;
         rd_count_q  <= rd_count_d;
         target_q    <= target_d;
         prev_y_q    <= prev_y_d;
         underflow_q <= underflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_pend_q   <= rd_go_c;
         rd_valid_q  <= rd_pend_q;
         if (rd_pend_q) rd_data_q <= ram_q;
      end
   end

   // Sample RAM with registered read port; contents are never reset
   always_ff @(posedge sys_clk) begin
      if (wr_en_c) mem[wr_addr_c] <= {bus.in_x, bus.in_y};
      if (rd_go_c) ram_q <= mem[rd_count_q[AW-1:0]];
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign wr_count     = wr_count_q;
   assign rd_count     = rd_count_q;
   assign underflow    = underflow_q;
endmodule
